// File: rtl/spi_slave_pkg.sv
// Shared types and command codes for the SPI slave front end.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    RX      = 3'd2,
    WAIT_TX = 3'd3,
    TX      = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] CMD_WR_ADDR = 3'b000;
  localparam logic [2:0] CMD_WR_DATA = 3'b001;
  localparam logic [2:0] CMD_RD_ADDR = 3'b110;
  localparam logic [2:0] CMD_RD_DATA = 3'b111;

  localparam logic [1:0] KIND_WR_ADDR = 2'd0;
  localparam logic [1:0] KIND_WR_DATA = 2'd1;
  localparam logic [1:0] KIND_RD_ADDR = 2'd2;

  function automatic logic is_rx_cmd(input logic [2:0] code);
    return (code == CMD_WR_ADDR) || (code == CMD_WR_DATA) || (code == CMD_RD_ADDR);
  endfunction

  function automatic logic [1:0] cmd_kind(input logic [2:0] code);
    logic [1:0] kind;
    kind = KIND_WR_ADDR;
    if (code == CMD_WR_DATA) kind = KIND_WR_DATA;
    if (code == CMD_RD_ADDR) kind = KIND_RD_ADDR;
    return kind;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Pin and register-side signals of the SPI slave; parity_err exists only
// with SPI_SLAVE_PARITY_EN defined.
interface spi_slave_ctrl_if #(parameter int DATA_W = 8);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] rx_data;
  logic [1:0]        rx_kind;
  logic              rx_valid;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              frame_err;
  logic              busy;
`ifdef SPI_SLAVE_PARITY_EN
  logic              parity_err;
`endif

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_kind, rx_valid, tx_req, tx_ready, frame_err, busy
`ifdef SPI_SLAVE_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_kind, rx_valid, tx_req, tx_ready, frame_err, busy
`ifdef SPI_SLAVE_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/spi_shifter.sv
// Shared parallel-load / serial-in register; its MSB is the serial output.
// Clear and reset win over load, load wins over shift; no backpressure.
module spi_shifter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr)  q <= '0;
    else if (load)   q <= load_dat;
    else if (shift)  q <= {q[W-2:0], sin};
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: 3-bit header, DATA_W payload in/out; rx_valid 1 cycle after last bit.
// Read data is held off via tx_ready/tx_valid; SPI_SLAVE_PARITY_EN adds an even-parity bit.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 2);
`ifdef SPI_SLAVE_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        hdr;
  logic [1:0]        kind_q;
  logic [2:0]        code;
  logic [DATA_W-1:0] sh_q;
  logic              sh_load, sh_shift, sh_clr, sh_sin;
  logic              abort;
  logic [DATA_W-1:0] rx_data_q;
  logic [1:0]        rx_kind_q;
  logic              rx_valid_q, tx_req_q, frame_err_q;
`ifdef SPI_SLAVE_PARITY_EN
  logic              par_q, parity_err_q;
`endif

  assign code = {hdr, bus.mosi};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.ss_n) state_nxt = HDR;
      HDR: begin
        if (bus.ss_n)                       state_nxt = IDLE;
        else if (cnt == CNT_W'(2)) begin
          if (is_rx_cmd(code))              state_nxt = RX;
          else if (code == CMD_RD_DATA)     state_nxt = WAIT_TX;
          else                              state_nxt = DONE;
        end
      end
      RX: begin
        if (bus.ss_n)                       state_nxt = IDLE;
        else if (cnt == LAST)               state_nxt = DONE;
      end
      WAIT_TX: begin
        if (bus.ss_n)                       state_nxt = IDLE;
        else if (bus.tx_valid)              state_nxt = TX;
      end
      TX: begin
        if (bus.ss_n)                       state_nxt = IDLE;
        else if (cnt == LAST)               state_nxt = DONE;
      end
      DONE:    if (bus.ss_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    abort        = bus.ss_n && (state == HDR || state == RX || state == WAIT_TX || state == TX);
    bus.busy     = (state != IDLE);
    bus.tx_ready = (state == WAIT_TX);
    sh_clr       = abort;
    sh_load      = (state == WAIT_TX) && !bus.ss_n && bus.tx_valid;
    // The parity bit, when present, is checked against the payload, not shifted in.
    sh_shift     = !bus.ss_n && ((state == TX) || ((state == RX) && (cnt < CNT_W'(DATA_W))));
    sh_sin       = (state == RX) && bus.mosi;
    bus.miso     = 1'b0;
    if (state == TX) begin
`ifdef SPI_SLAVE_PARITY_EN
      bus.miso = (cnt == CNT_W'(DATA_W)) ? par_q : sh_q[DATA_W-1];
`else
      bus.miso = sh_q[DATA_W-1];
`endif
    end
  end

  spi_shifter #(.W(DATA_W)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .load     (sh_load),
    .load_dat (bus.tx_data),
    .shift    (sh_shift),
    .sin      (sh_sin),
    .q        (sh_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      hdr          <= '0;
      kind_q       <= '0;
      rx_data_q    <= '0;
      rx_kind_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (abort) begin
        frame_err_q <= 1'b1;
        cnt         <= '0;
        hdr         <= '0;
      end else begin
        case (state)
          IDLE: if (!bus.ss_n) begin
            hdr <= {1'b0, bus.mosi};
            cnt <= CNT_W'(1);
          end
          HDR: begin
            hdr <= {hdr[0], bus.mosi};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(2)) begin
              cnt <= '0;
              if (is_rx_cmd(code))          kind_q   <= cmd_kind(code);
              else if (code == CMD_RD_DATA) tx_req_q <= 1'b1;
              else                          frame_err_q <= 1'b1;
            end
          end
          RX: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
`ifdef SPI_SLAVE_PARITY_EN
              if ((^sh_q) == bus.mosi) begin
                rx_data_q  <= sh_q;
                rx_kind_q  <= kind_q;
                rx_valid_q <= 1'b1;
              end else begin
                parity_err_q <= 1'b1;
              end
`else
              rx_data_q  <= {sh_q[DATA_W-2:0], bus.mosi};
              rx_kind_q  <= kind_q;
              rx_valid_q <= 1'b1;
`endif
            end
          end
          WAIT_TX: if (bus.tx_valid) begin
            cnt <= '0;
`ifdef SPI_SLAVE_PARITY_EN
            par_q <= ^bus.tx_data;
`endif
          end
          TX:      cnt <= cnt + CNT_W'(1);
          default: cnt <= '0;
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_kind   = rx_kind_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.frame_err = frame_err_q;
`ifdef SPI_SLAVE_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
Parametrised SPI slave front end. It decodes a 3-bit command header, deserialises a DATA_W-bit payload for write-address, write-data and read-address frames, and serialises DATA_W bits of read data on miso for read-data frames. It runs on the system clk, which is the SPI sampling clock, with mosi sampled every cycle while ss_n is low. It sits between the SPI pins and the register/RAM access logic, and reports framing errors.

Parameters:
DATA_W, 8, payload and read-data width in bits (2..32)
CNT_W, $clog2(DATA_W+2), bit counter width (derived; not overridden)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
ss_n  in  1  slave select, active-low
mosi  in  1  serial data in, MSB first
miso  out  1  serial data out, MSB first
rx_data  out  DATA_W  deserialised payload
rx_kind  out  2  frame type of rx_data: 0 WR_ADDR, 1 WR_DATA, 2 RD_ADDR
rx_valid  out  1  one-cycle pulse; rx_data and rx_kind are valid
tx_req  out  1  one-cycle pulse on read-data header decode
tx_data  in  DATA_W  read data to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  high while the block waits for read data
frame_err  out  1  one-cycle pulse on a bad header or an early ss_n release
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; cnt, hdr, shift registers 0; miso, rx_valid, tx_req, tx_ready, frame_err, busy = 0. rx_data = 0, rx_kind = 0.
- Header codes (mosi order b2 b1 b0): 000 WR_ADDR, 001 WR_DATA, 110 RD_ADDR, 111 RD_DATA; all other codes are illegal.
- IDLE: when ss_n=0, sample b2 into hdr, set cnt=1, go to HDR.
- HDR: shift mosi into hdr. When cnt==2, decode {hdr[1:0],mosi} in the same cycle:
  - legal write or RD_ADDR code: go to RX, cnt=0.
  - RD_DATA: pulse tx_req next cycle, go to WAIT_TX.
  - illegal code: pulse frame_err, go to DONE.
- RX: shift mosi into the payload register, MSB first, and increment cnt. On the sample with cnt==DATA_W-1, go to DONE. In the following cycle, rx_data is updated and rx_valid pulses with rx_kind; latency is 1 cycle after the last bit.
- WAIT_TX: tx_ready=1. When tx_valid&&tx_ready, load tx_data into the shifter, go to TX, cnt=0. mosi is ignored.
- TX: miso = shifter MSB, registered. One bit per cycle, and the first bit appears on the cycle after load. After DATA_W bits, go to DONE; miso returns to 0.
- DONE: ignore mosi. When ss_n=1, go to IDLE. No error is raised here.
- Early release: ss_n=1 while in HDR, RX, WAIT_TX or TX aborts the frame. frame_err pulses next cycle, state goes to IDLE, rx_valid is not asserted, the shifter is cleared, and miso=0.
- ss_n=0 held continuously after DONE→IDLE cannot happen, because DONE exits only on ss_n=1. Back-to-back frames need at least 1 cycle of ss_n high.
- tx_valid arriving outside WAIT_TX is ignored.
- Reset has priority over every event, including mid-frame. A reset mid-frame produces no rx_valid and no frame_err.
- miso = 0 whenever not in TX.

Optional Feature:
Macro SPI_SLAVE_PARITY_EN.
- With the macro: RX collects DATA_W+1 bits. The final bit is even parity over the payload. On mismatch, rx_valid is suppressed and port parity_err (out, 1) pulses in the same cycle rx_valid would have pulsed. TX appends an even-parity bit after the DATA_W data bits.
- Without the macro: there is no parity_err port and no parity bit; the protocol is exactly as above.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum (IDLE, HDR, RX, WAIT_TX, TX, DONE)
  - 3-bit header constants CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA
  - rx_kind constants
- Sub-module spi_shifter (DATA_W-bit parallel-load/serial-in/serial-out register with MSB out) is used once, shared between RX and TX.

Test Plan:
- WR_DATA, DATA_W=8: ss_n low, mosi 001 then 0xA5 → rx_valid pulse 1 cycle after the last bit, rx_data=0xA5, rx_kind=1, frame_err=0.
- RD_DATA: header 111 → tx_req pulse. tx_valid with 0x3C two cycles later → miso shows 0,0,1,1,1,1,0,0 on the cycles following load, then 0.
- Illegal header 010 → frame_err pulse, no rx_valid. The 8 following mosi bits are ignored, and IDLE is reached after ss_n goes high.
- ss_n rises after 4 payload bits of WR_ADDR → frame_err pulse, no rx_valid. An immediate new frame 110 + 0x81 → rx_valid, rx_data=0x81, rx_kind=2.
- rst=1 mid-TX → all outputs 0 on the next edge; rst released → IDLE, busy=0.
- With SPI_SLAVE_PARITY_EN: WR_DATA 0xA5 + parity 0 → rx_valid. The same frame with parity 1 → parity_err pulse, no rx_valid.
